booth_result_buffer: RTL

- Sits directly downstream of the 8-bit Booth pipelined multiplier core.
- Captures the core's fixed-latency output (product plus valid strobe) into a small FIFO and presents it on a valid/ready stream.
- The core cannot stall, so this block does credit accounting. It counts in-flight operations plus buffered results and tells the upstream issuer when a new operand pair may enter the core.
- No result can ever arrive at a full buffer when the issuer honours the credit signal.

---
 rtl/booth_result_buffer_if.sv | 41 ++++
 rtl/booth_result_buffer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/booth_result_buffer_if.sv
// Stream/credit bundle between the Booth core, its issuer and the result consumer.
// Optional tag lane is present when BOOTH_RB_TAG_EN is defined.
interface booth_result_buffer_if #(
  parameter int PW    = 16,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          issue;
  logic          credit_ok;
  logic          r_valid;
  logic [PW-1:0] r_data;
  logic          m_valid;
  logic          m_ready;
  logic [PW-1:0] m_data;
  logic [LW-1:0] level;
  logic          err;
`ifdef BOOTH_RB_TAG_EN
  logic [3:0]    m_tag;

  modport master (
    output issue, r_valid, r_data, m_ready,
    input  credit_ok, m_valid, m_data, level, err, m_tag
  );

  modport slave (
    input  issue, r_valid, r_data, m_ready,
    output credit_ok, m_valid, m_data, level, err, m_tag
  );
`else
  modport master (
    output issue, r_valid, r_data, m_ready,
    input  credit_ok, m_valid, m_data, level, err
  );

  modport slave (
    input  issue, r_valid, r_data, m_ready,
    output credit_ok, m_valid, m_data, level, err
  );
`endif
endinterface

// File: rtl/booth_result_buffer.sv
// Result FIFO with credit accounting behind the non-stallable 8-bit Booth multiplier core.
// Define BOOTH_RB_TAG_EN to carry a 4-bit issue sequence tag alongside each product.
module booth_result_buffer #(
  parameter int DEPTH        = 8,
  parameter int PW           = 16,
  parameter int MAX_INFLIGHT = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  booth_result_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int SW = ((LW > IW) ? LW : IW) + 1;
  localparam int CORE_LAT = 6;

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [IW-1:0] inflight_q;
  logic          m_valid_q;
  logic [PW-1:0] m_data_q;
  logic          err_q;

  logic          pop;
  logic          full;
  logic          push;
  logic          drop;
  logic          issue_bad;
  logic          credit_ok;
  logic [AW-1:0] rd_ptr_n;
  logic [LW-1:0] level_n;
  logic [LW-1:0] remain;
  logic [PW-1:0] head_n;
  logic [IW-1:0] inflight_n;
  logic [SW-1:0] credit_sum;

  // Credit is a pure decode of registered level and in-flight count.
  always_comb begin
    credit_sum = SW'(level_q) + SW'(inflight_q);
    credit_ok  = credit_sum < SW'(DEPTH);
  end

  always_comb begin
    pop       = m_valid_q & bus.m_ready;
    full      = (level_q == LW'(DEPTH));
    push      = bus.r_valid & (~full | pop);
    drop      = bus.r_valid & full & ~pop;
    issue_bad = bus.issue & (~credit_ok | (inflight_q == IW'(MAX_INFLIGHT)));
    rd_ptr_n  = rd_ptr + AW'(pop);
    level_n   = level_q + LW'(push) - LW'(pop);
    remain    = level_q - LW'(pop);
    // With nothing left behind the popped head, the new head is the word being pushed.
    head_n    = (remain == '0) ? bus.r_data : mem[rd_ptr_n];
  end

  always_comb begin
    inflight_n = inflight_q;
    if (bus.issue && !bus.r_valid) begin
      if (inflight_q != IW'(MAX_INFLIGHT)) begin
        inflight_n = inflight_q + 1'b1;
      end
    end else if (!bus.issue && bus.r_valid) begin
      if (inflight_q != '0) begin
        inflight_n = inflight_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= bus.r_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      inflight_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr     <= rd_ptr_n;
      level_q    <= level_n;
      m_valid_q  <= (level_n != '0);
      if (level_n != '0) begin
        m_data_q <= head_n;
      end
      inflight_q <= inflight_n;
      if (drop || issue_bad) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef BOOTH_RB_TAG_EN
  logic [3:0] tag_cnt;
  logic [3:0] tag_dl  [CORE_LAT];
  logic [3:0] tag_mem [DEPTH];
  logic [3:0] m_tag_q;

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      tag_mem[wr_ptr] <= tag_dl[CORE_LAT-1];
    end
  end

  // The delay line shifts every cycle so its tail lines up with the core's v_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_cnt <= '0;
      for (int i = 0; i < CORE_LAT; i++) begin
        tag_dl[i] <= '0;
      end
      m_tag_q <= '0;
    end else begin
      if (bus.issue) begin
        tag_cnt <= tag_cnt + 1'b1;
      end
      tag_dl[0] <= tag_cnt;
      for (int i = 1; i < CORE_LAT; i++) begin
        tag_dl[i] <= tag_dl[i-1];
      end
      if (level_n != '0) begin
        m_tag_q <= (remain == '0) ? tag_dl[CORE_LAT-1] : tag_mem[rd_ptr_n];
      end
    end
  end

  assign bus.m_tag = m_tag_q;
`endif

  assign bus.credit_ok = credit_ok;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.level     = level_q;
  assign bus.err       = err_q;

endmodule
